// File: rtl/pipe_pkg.sv
// Shared decode definitions for the MIPS pipeline: opcodes, control widths,
// the packed ID/EX control bundle and the opcode-to-control decoder.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int WB_W    = 2;
  localparam int M_W     = 3;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic [WB_W-1:0]    wb;      // {regwrite, memtoreg}
    logic [M_W-1:0]     m;       // {branch, memread, memwrite}
    logic               regdst;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
  } ctl_t;

  localparam ctl_t BUBBLE = ctl_t'(0);

  function automatic ctl_t decode_ctl(input logic [5:0] op);
    ctl_t c;
    c = BUBBLE;
    case (op)
      OP_RTYPE: begin c.wb = 2'b10; c.regdst = 1'b1; c.aluop = 2'b10; end
      OP_LW:    begin c.wb = 2'b11; c.m = 3'b010; c.alusrc = 1'b1; end
      OP_SW:    begin c.m = 3'b001; c.alusrc = 1'b1; end
      OP_BEQ:   begin c.m = 3'b100; c.aluop = 2'b01; end
      OP_ADDI:  begin c.wb = 2'b10; c.alusrc = 1'b1; end
      default:  c = BUBBLE;
    endcase
    return c;
  endfunction

  // rt is a source operand only for these; for lw/addi it is the destination
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with synchronous clear and hard-wired r0.
// Same-cycle write/read forwarding is enabled by defining ID_WB_BYPASS_EN.
module regfile_2r1w
  import pipe_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] raw1, raw2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign raw1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign raw2 = (raddr2 == '0) ? '0 : regs[raddr2];

`ifdef ID_WB_BYPASS_EN
  assign rdata1 = (we && (waddr != '0) && (waddr == raddr1)) ? wdata : raw1;
  assign rdata2 = (we && (waddr != '0) && (waddr == raddr2)) ? wdata : raw2;
`else
  assign rdata1 = raw1;
  assign rdata2 = raw2;
`endif

endmodule

// File: rtl/id_stage_p.sv
// Parametrised MIPS decode stage: register file, control decode, load-use
// stall and branch squash feeding the ID/EX register. Optional: ID_WB_BYPASS_EN.
module id_stage_p
  import pipe_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_instr,
  input  logic [XLEN-1:0]   if_id_npc,
  input  logic              if_id_valid,
  input  logic              ex_mem_pcsrc,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic [XLEN-1:0]   wb_writedata,
  output logic              stall,
  output logic              id_ex_valid,
  output logic [1:0]        wb_ctl,
  output logic [2:0]        m_ctl,
  output logic              regdst,
  output logic              alusrc,
  output logic [1:0]        aluop,
  output logic [XLEN-1:0]   npc,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  output logic [XLEN-1:0]   sext,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd
);

  logic [5:0]        op_id;
  logic [REG_AW-1:0] rs_id, rt_id, rd_id;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  ctl_t              ctl_q;
  logic              hazard;

  assign op_id = if_id_instr[31:26];
  assign rs_id = if_id_instr[21 +: REG_AW];
  assign rt_id = if_id_instr[16 +: REG_AW];
  assign rd_id = if_id_instr[11 +: REG_AW];

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs_id),
    .raddr2 (rt_id),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (mem_wb_regwrite),
    .waddr  (mem_wb_rd),
    .wdata  (wb_writedata)
  );

  // A load in EX whose destination feeds this instruction must wait one cycle
  assign hazard = id_ex_valid && ctl_q.m[1] && (rt != '0) &&
                  ((rt == rs_id) || ((rt == rt_id) && uses_rt(op_id)));
  assign stall  = hazard && if_id_valid && !ex_mem_pcsrc && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n || ex_mem_pcsrc || stall || !if_id_valid) begin
      id_ex_valid <= 1'b0;
      ctl_q       <= BUBBLE;
      npc         <= '0;
      rdata1      <= '0;
      rdata2      <= '0;
      sext        <= '0;
      rs          <= '0;
      rt          <= '0;
      rd          <= '0;
    end else begin
      id_ex_valid <= 1'b1;
      ctl_q       <= decode_ctl(op_id);
      npc         <= if_id_npc;
      rdata1      <= rf_rdata1;
      rdata2      <= rf_rdata2;
      sext        <= XLEN'($signed(if_id_instr[15:0]));
      rs          <= rs_id;
      rt          <= rt_id;
      rd          <= rd_id;
    end
  end

  assign wb_ctl = ctl_q.wb;
  assign m_ctl  = ctl_q.m;
  assign regdst = ctl_q.regdst;
  assign alusrc = ctl_q.alusrc;
  assign aluop  = ctl_q.aluop;

endmodule

// File: tb/tb_id_stage_p.sv
// Self-checking bench for id_stage_p: reference model plus directed literal checks.
module tb_id_stage_p;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_npc;
  logic            if_id_valid;
  logic            ex_mem_pcsrc;
  logic [AW-1:0]   mem_wb_rd;
  logic            mem_wb_regwrite;
  logic [XLEN-1:0] wb_writedata;
  logic            stall, id_ex_valid, regdst, alusrc;
  logic [1:0]      wb_ctl, aluop;
  logic [2:0]      m_ctl;
  logic [XLEN-1:0] npc, rdata1, rdata2, sext;
  logic [AW-1:0]   rs, rt, rd;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  id_stage_p #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .if_id_valid(if_id_valid), .ex_mem_pcsrc(ex_mem_pcsrc), .mem_wb_rd(mem_wb_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .wb_writedata(wb_writedata), .stall(stall),
    .id_ex_valid(id_ex_valid), .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst),
    .alusrc(alusrc), .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
    .sext(sext), .rs(rs), .rt(rt), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural register values and the expected ID/EX contents
  logic [XLEN-1:0] mregs [NREG];
  logic            e_valid, e_is_load;
  logic [8:0]      e_ctl;
  logic [XLEN-1:0] e_npc, e_r1, e_r2, e_sext;
  logic [AW-1:0]   e_rs, e_rt, e_rd;

  // Control table {wb, m, regdst, aluop, alusrc} straight from the opcode list
  function automatic logic [8:0] model_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1_10_0;
      6'h23:   return 9'b11_010_0_00_1;
      6'h2B:   return 9'b00_001_0_00_1;
      6'h04:   return 9'b00_100_0_01_0;
      6'h08:   return 9'b10_000_0_00_1;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (mem_wb_regwrite && mem_wb_rd == a) return wb_writedata;
`endif
    return mregs[a];
  endfunction

  function automatic logic model_stall();
    logic [5:0]    op;
    logic [AW-1:0] s, t;
    logic          reads_rt;
    op = if_id_instr[31:26];
    s  = if_id_instr[25:21];
    t  = if_id_instr[20:16];
    reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return rst_n && if_id_valid && !ex_mem_pcsrc && e_valid && e_is_load &&
           (e_rt != 0) && (e_rt == s || (e_rt == t && reads_rt));
  endfunction

  always @(posedge clk) begin
    logic st;
    logic [XLEN-1:0] r1, r2;
    st = model_stall();
    r1 = model_read(if_id_instr[25:21]);
    r2 = model_read(if_id_instr[20:16]);
    if (!rst_n || ex_mem_pcsrc || st || !if_id_valid) begin
      e_valid = 0; e_is_load = 0; e_ctl = '0; e_npc = '0; e_r1 = '0; e_r2 = '0;
      e_sext = '0; e_rs = '0; e_rt = '0; e_rd = '0;
    end else begin
      e_valid   = 1;
      e_is_load = (if_id_instr[31:26] == 6'h23);
      e_ctl     = model_ctl(if_id_instr[31:26]);
      e_npc     = if_id_npc;
      e_r1      = r1;
      e_r2      = r2;
      e_sext    = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      e_rs      = if_id_instr[25:21];
      e_rt      = if_id_instr[20:16];
      e_rd      = if_id_instr[15:11];
    end
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mregs[i] = '0;
    end else if (mem_wb_regwrite && mem_wb_rd != 0) begin
      mregs[mem_wb_rd] = wb_writedata;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model stall", stall, model_stall());
      checkOutput("model valid", id_ex_valid, e_valid);
      checkOutput("model ctl", {wb_ctl, m_ctl, regdst, aluop, alusrc}, e_ctl);
      checkOutput("model npc", npc, e_npc);
      checkOutput("model rdata1", rdata1, e_r1);
      checkOutput("model rdata2", rdata2, e_r2);
      checkOutput("model sext", sext, e_sext);
      checkOutput("model rs/rt/rd", {rs, rt, rd}, {e_rs, e_rt, e_rd});
    end
  end

  task automatic drive(input logic [31:0] instr, input logic valid, input logic pcsrc,
                       input logic we, input logic [AW-1:0] wrd, input logic [XLEN-1:0] wd);
    if_id_instr     = instr;
    if_id_valid     = valid;
    ex_mem_pcsrc    = pcsrc;
    mem_wb_regwrite = we;
    mem_wb_rd       = wrd;
    wb_writedata    = wd;
    if_id_npc       = if_id_npc + 4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic pcsrc,
                               input logic we, input logic [AW-1:0] wrd, input logic [XLEN-1:0] wd);
    drive(instr, valid, pcsrc, we, wrd, wd);
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_id_npc = '0;
    drive(32'h00221820, 1, 0, 1, 5'd3, 32'h1234);
    step();
    check_en = 1'b1;
    step();
    checkOutput("reset valid", id_ex_valid, 0);
    checkOutput("reset ctl", {wb_ctl, m_ctl, regdst, aluop, alusrc}, 0);
    checkOutput("reset data", {npc, rdata1, rdata2, sext}, 0);
    checkOutput("reset stall", stall, 0);
    rst_n = 1'b1;

    // add r3,r5,r0: r5 must read back cleared
    applyStimulus(32'h00A01820, 1, 0, 0, 0, 0);
    checkOutput("r5 after reset", rdata1, 0);

    applyStimulus(32'h0, 0, 0, 1, 5'd1, 32'd7);
    applyStimulus(32'h0, 0, 0, 1, 5'd2, 32'd9);
    applyStimulus(32'h00221820, 1, 0, 0, 0, 0);
    checkOutput("add wb_ctl", wb_ctl, 2'b10);
    checkOutput("add aluop", aluop, 2'b10);
    checkOutput("add regdst", regdst, 1);
    checkOutput("add rdata1", rdata1, 7);
    checkOutput("add rdata2", rdata2, 9);
    checkOutput("add rd", rd, 3);

    // lw r4,0(r1) then add r5,r4,r4: one bubble
    applyStimulus(32'h8C240000, 1, 0, 0, 0, 0);
    checkOutput("lw ctl", {wb_ctl, m_ctl}, 5'b11_010);
    drive(32'h00842820, 1, 0, 0, 0, 0);
    #2 checkOutput("load-use stall", stall, 1);
    step();
    checkOutput("bubble valid", id_ex_valid, 0);
    checkOutput("bubble ctl", {wb_ctl, m_ctl}, 0);
    checkOutput("stall released", stall, 0);
    step();
    checkOutput("add after stall", {id_ex_valid, rd}, {1'b1, 5'd5});

    // flush beats stall
    applyStimulus(32'h8C240000, 1, 0, 0, 0, 0);
    drive(32'h00842820, 1, 1, 0, 0, 0);
    #2 checkOutput("flush stall", stall, 0);
    step();
    checkOutput("flush valid", id_ex_valid, 0);
    checkOutput("flush ctl", {wb_ctl, m_ctl}, 0);

    // lw r4 then addi r4,r1,5: rt is a destination, no stall
    applyStimulus(32'h8C240000, 1, 0, 0, 0, 0);
    drive(32'h20240005, 1, 0, 0, 0, 0);
    #2 checkOutput("addi rt no stall", stall, 0);
    step();
    // lw r0 never stalls
    applyStimulus(32'h8C200000, 1, 0, 0, 0, 0);
    drive(32'h00002820, 1, 0, 0, 0, 0);
    #2 checkOutput("lw r0 no stall", stall, 0);
    step();
    // lw r4 then beq r1,r4
    applyStimulus(32'h8C240000, 1, 0, 0, 0, 0);
    drive(32'h10240003, 1, 0, 0, 0, 0);
    #2 checkOutput("beq stall", stall, 1);
    step();
    step();
    checkOutput("beq ctl", {m_ctl, aluop, alusrc}, 6'b100_01_0);

    applyStimulus(32'hAC240008, 1, 0, 0, 0, 0);
    checkOutput("sw ctl", {wb_ctl, m_ctl, alusrc}, 6'b00_001_1);
    applyStimulus(32'h08000000, 1, 0, 0, 0, 0);
    checkOutput("unknown op", {id_ex_valid, wb_ctl, m_ctl, regdst, aluop, alusrc}, 10'b1_000000000);

    // same-cycle write/read of r6
    applyStimulus(32'h00C01820, 1, 0, 1, 5'd6, 32'hDEAD);
`ifdef ID_WB_BYPASS_EN
    checkOutput("same-cycle r6", rdata1, 32'hDEAD);
`else
    checkOutput("same-cycle r6", rdata1, 0);
`endif
    applyStimulus(32'h00C01820, 1, 0, 0, 0, 0);
    checkOutput("r6 later", rdata1, 32'hDEAD);
    applyStimulus(32'h00001820, 1, 0, 1, 5'd0, 32'h55);
    checkOutput("r0 same-cycle", rdata1, 0);
    applyStimulus(32'h00001820, 1, 0, 0, 0, 0);
    checkOutput("r0 later", rdata1, 0);

    applyStimulus(32'h2007FFFF, 1, 0, 0, 0, 0);
    checkOutput("addi sext", sext, 32'hFFFFFFFF);
    checkOutput("addi alusrc", alusrc, 1);
    checkOutput("addi rt", rt, 7);

    // reset mid-operation clears ID/EX and the register file
    rst_n = 1'b0;
    applyStimulus(32'h00221820, 1, 0, 0, 0, 0);
    checkOutput("mid reset valid", id_ex_valid, 0);
    rst_n = 1'b1;
    applyStimulus(32'h00221820, 1, 0, 0, 0, 0);
    checkOutput("regs cleared", {rdata1, rdata2}, 0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
